// File: rtl/int_divmod_unit.sv
// int_divmod_unit
// Iterative signed integer divide/modulo for the integer EX path.
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// cycle, with C-style truncation sign fix-up applied on the last iteration.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   start        in   EX issues div/mod; held high while stalled
//   op_mod       in   0 = quotient, 1 = remainder (latched on accept)
//   dividend     in   signed numerator
//   divisor      in   signed denominator
//   stall        out  combinational; EX must hold its instruction
//   busy         out  high while iterating (RUN)
//   done         out  one-cycle pulse, result valid
//   result       out  quotient or remainder; held until next accept
//   div_by_zero  out  qualifies done; divisor was zero
//   state_dbg    out  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: an op is accepted on the edge where state is IDLE and start is
// high. stall is raised combinationally in that cycle and stays high through
// RUN, so EX holds start and operands until done. done is a single-cycle
// pulse in DONE with stall low; start is ignored in DONE, so a back-to-back
// op is accepted in the following IDLE cycle.
module int_divmod_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_mod,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             mod_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic             accept;
  logic             divisor_zero;
  logic             last_iter;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  logic [WIDTH:0]   trial_shift;
  logic [WIDTH:0]   trial_diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  assign accept       = (state == IDLE) && start;
  assign divisor_zero = (divisor == '0);
  assign last_iter    = (cnt_q == CW'(WIDTH - 1));

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which reads correctly as an unsigned magnitude.
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

  // One restoring step. The shifted partial remainder is kept one bit wider
  // so the borrow of the trial subtraction lands in the top bit.
  always_comb begin
    trial_shift = {rem_q, quo_q[WIDTH-1]};
    trial_diff  = trial_shift - {1'b0, dvs_q};
    rem_nxt     = trial_shift[WIDTH-1:0];
    quo_nxt     = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial_diff[WIDTH]) begin
      rem_nxt = trial_diff[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Negating zero yields zero, so zero results never come out negative.
  assign quo_fixed = neg_quo_q ? -quo_nxt : quo_nxt;
  assign rem_fixed = neg_rem_q ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = divisor_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      mod_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        if (divisor_zero) begin
          result      <= op_mod ? dividend : '1;
          div_by_zero <= 1'b1;
        end else begin
          rem_q       <= '0;
          quo_q       <= dividend_mag;
          dvs_q       <= divisor_mag;
          cnt_q       <= '0;
          mod_q       <= op_mod;
          neg_quo_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_q   <= dividend[WIDTH-1];
          div_by_zero <= 1'b0;
        end
      end else if (state == RUN) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q + CW'(1);
        if (last_iter) begin
          result <= mod_q ? rem_fixed : quo_fixed;
        end
      end
    end
  end

  assign stall     = accept || (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_int_divmod_unit.sv
// Testbench for int_divmod_unit: directed vectors with hand-computed
// results. The driver pushes expected responses into a queue on issue; a
// monitor pops and compares on every done pulse.
module tb_int_divmod_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         op_mod;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_z_q[$];

  int_divmod_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op_mod(op_mod),
    .dividend(dividend),
    .divisor(divisor),
    .stall(stall),
    .busy(busy),
    .done(done),
    .result(result),
    .div_by_zero(div_by_zero),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_with_stall", {31'd0, stall}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("result", result, exp_q.pop_front());
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_z_q.pop_front()});
      end
    end
  end

  // Driver: called at a negedge. Drives one op, checks stall per cycle and
  // the cycle index at which done appears. mid_b replaces the divisor in
  // cycle 5 of the op (pass b itself for no change).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [W-1:0] exp_r, input logic exp_z, input int exp_lat,
                        input logic hold_after, input logic [W-1:0] mid_b);
    bit found;
    found    = 1'b0;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    op_mod   = m;
    exp_q.push_back(exp_r);
    exp_z_q.push_back(exp_z);
    #1;
    check("stall_cycle0", {31'd0, stall}, 32'd1);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 5) divisor = mid_b;
      if (done) begin
        check("done_latency", k, exp_lat);
        found = 1'b1;
        break;
      end else begin
        check("stall_while_pending", {31'd0, stall}, 32'd1);
      end
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
    if (!hold_after) start = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    op_mod   = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic divide / modulo
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 1'b0, 33, 1'b0, 32'd7);
    @(negedge clk);
    run_op(32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 33, 1'b0, 32'd7);
    @(negedge clk);
    run_op(32'hFFFFFF9C, 32'd7, 1'b0, 32'hFFFFFFF2, 1'b0, 33, 1'b0, 32'd7);
    @(negedge clk);

    // divide by zero, result held afterwards
    run_op(32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1, 1'b0, 32'd0);
    @(negedge clk);
    run_op(32'd5, 32'd0, 1'b1, 32'd5, 1'b1, 1, 1'b0, 32'd0);
    @(negedge clk);
    check("hold_result", result, 32'd5);
    check("hold_dbz", {31'd0, div_by_zero}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // signed corners
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b0, 33, 1'b0, 32'hFFFFFFFF);
    @(negedge clk);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b0, 33, 1'b0, 32'hFFFFFFFF);
    @(negedge clk);
    run_op(32'd7, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFD, 1'b0, 33, 1'b0, 32'hFFFFFFFE);
    @(negedge clk);
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, 1'b0, 33, 1'b0, 32'hFFFFFFFE);
    @(negedge clk);
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 1'b0, 33, 1'b0, 32'd2);
    @(negedge clk);
    run_op(32'd0, 32'd5, 1'b0, 32'd0, 1'b0, 33, 1'b0, 32'd5);
    @(negedge clk);
    run_op(32'hFFFFFFFA, 32'd3, 1'b1, 32'd0, 1'b0, 33, 1'b0, 32'd3);
    @(negedge clk);

    // reset in the middle of RUN
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd7;
    op_mod   = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_run_busy", {31'd0, busy}, 32'd0);
    check("rst_run_stall", {31'd0, stall}, 32'd1);
    check("rst_run_result", result, 32'd0);
    check("rst_run_done", {31'd0, done}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    run_op(32'd9, 32'd3, 1'b0, 32'd3, 1'b0, 33, 1'b0, 32'd3);
    @(negedge clk);

    // back-to-back with a divisor change during RUN
    run_op(32'd1000, 32'd10, 1'b0, 32'd100, 1'b0, 33, 1'b1, 32'd3);
    dividend = 32'd50;
    divisor  = 32'd7;
    op_mod   = 1'b1;
    @(negedge clk);
    run_op(32'd50, 32'd7, 1'b1, 32'd1, 1'b0, 33, 1'b0, 32'd7);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
